// File: rtl/datapath_ctrl_pkg.sv
// Shared encodings for the multiply-and-clamp sequencer: FSM state codes and r5 source select.
package datapath_ctrl_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    LOAD = S_LOAD,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_e;

  localparam logic SEL_R5_CLAMP = 1'b0;
  localparam logic SEL_R5_PROD  = 1'b1;

endpackage

// File: rtl/datapath_controller.sv
// Sequencer computing r5 = min(A*B, C) by repeated addition on the companion datapath.
// Optional RESULT_HOLD_EN adds a result register that captures r5 on each done pulse.
module datapath_controller
  import datapath_ctrl_pkg::*;
#(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic         cmp_res,
  input  logic         nor_res,
  input  logic [n-1:0] r5,
  output logic         reset_regs,
  output logic         sel_r1,
  output logic         sel_r5,
  output logic         en,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] iters,
`ifdef RESULT_HOLD_EN
  output logic [n-1:0] result,
`endif
  output logic [1:0]   dbg_state
);

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse with r5 valid
  // in that cycle; busy covers LOAD, RUN and DONE; abort only acts in LOAD/RUN.
  state_e       state_q, state_d;
  logic         reset_regs_q, reset_regs_d;
  logic         sel_r1_q, sel_r1_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [n-1:0] iters_q, iters_d;
  logic         exit_w;

  assign exit_w = nor_res | cmp_res;

  // en and sel_r5 must act on the same edge that sees the exit condition.
  always_comb begin
    en     = (state_q == RUN) && !abort && !exit_w;
    sel_r5 = (state_q == RUN) ? ~cmp_res : SEL_R5_PROD;
  end

  always_comb begin
    state_d      = state_q;
    reset_regs_d = 1'b1;
    sel_r1_d     = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    iters_d      = iters_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = LOAD;
          reset_regs_d = 1'b0;
          busy_d       = 1'b1;
          iters_d      = '0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          state_d  = RUN;
          sel_r1_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (exit_w) begin
          state_d = DONE;
          busy_d  = 1'b1;
          done_d  = 1'b1;
        end else begin
          sel_r1_d = 1'b1;
          busy_d   = 1'b1;
          iters_d  = iters_q + n'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      reset_regs_q <= 1'b1;
      sel_r1_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      iters_q      <= '0;
    end else begin
      state_q      <= state_d;
      reset_regs_q <= reset_regs_d;
      sel_r1_q     <= sel_r1_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      iters_q      <= iters_d;
    end
  end

  assign reset_regs = reset_regs_q;
  assign sel_r1     = sel_r1_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign iters      = iters_q;
  assign dbg_state  = state_q;

`ifdef RESULT_HOLD_EN
  logic [n-1:0] result_q, result_d;

  always_comb begin
    result_d = done_q ? r5 : result_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) result_q <= '0;
    else       result_q <= result_d;
  end

  assign result = result_q;
`else
  // Without the hold register r5 is read directly by the consumer on done.
  logic unused_r5;
  assign unused_r5 = ^r5;
`endif

endmodule

// File: tb/tb_datapath_controller.sv
// Directed bench: controller paired with a behavioural multiply-and-clamp datapath.
module tb_datapath_controller;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic       cmp_res, nor_res;
  logic       reset_regs, sel_r1, sel_r5, en, busy, done;
  logic [7:0] iters;
  logic [1:0] dbg_state;
`ifdef RESULT_HOLD_EN
  logic [7:0] result;
`endif

  logic [7:0] a_in, b_in, c_in;
  logic [7:0] r1 = '0, r2 = '0, r3 = '0, r4 = '0, r5 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  datapath_controller #(.n(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cmp_res(cmp_res), .nor_res(nor_res), .r5(r5),
    .reset_regs(reset_regs), .sel_r1(sel_r1), .sel_r5(sel_r5), .en(en),
    .busy(busy), .done(done), .iters(iters),
`ifdef RESULT_HOLD_EN
    .result(result),
`endif
    .dbg_state(dbg_state)
  );

  // Datapath: r1 = min / countdown, r2 = max, r3 = C, r4 = accumulator, r5 = output.
  assign cmp_res = r4 > r3;
  assign nor_res = (r1 == 8'd0);

  always @(posedge clk) begin
    r1 <= sel_r1 ? r1 - 8'd1 : ((a_in < b_in) ? a_in : b_in);
    r2 <= (a_in < b_in) ? b_in : a_in;
    r3 <= c_in;
    if (!reset_regs) r4 <= 8'd0;
    else if (en)     r4 <= r4 + r2;
    if (nor_res | cmp_res) r5 <= sel_r5 ? r4 : r3;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input int exp_lat, input logic [7:0] exp_r5,
                        input logic [7:0] exp_it, input string tag);
    int cyc;
    a_in = a; b_in = b; c_in = c; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    check({tag, "_load_busy"}, 32'(busy), 32'd1);
    check({tag, "_load_clear"}, 32'(reset_regs), 32'd0);
    while (!done && cyc < 64) begin
      tick();
      cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_r5"}, 32'(r5), 32'(exp_r5));
    check({tag, "_iters"}, 32'(iters), 32'(exp_it));
    tick();
    check({tag, "_post_done"}, 32'(done), 32'd0);
    check({tag, "_post_busy"}, 32'(busy), 32'd0);
    check({tag, "_iters_held"}, 32'(iters), 32'(exp_it));
`ifdef RESULT_HOLD_EN
    check({tag, "_result"}, 32'(result), 32'(exp_r5));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reset_regs"}, 32'(reset_regs), 32'd1);
    check({tag, "_sel_r1"}, 32'(sel_r1), 32'd0);
    check({tag, "_sel_r5"}, 32'(sel_r5), 32'd1);
    check({tag, "_en"}, 32'(en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_iters"}, 32'(iters), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int cyc;
    int ndone;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    a_in = 8'd0; b_in = 8'd0; c_in = 8'd0;
    tick();
    tick();
    check_reset_outputs("por");
`ifdef RESULT_HOLD_EN
    check("por_result", 32'(result), 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Plain product, clamp, zero operand, simultaneous exits.
    run_op(8'd3, 8'd5, 8'd100, 6, 8'd15, 8'd3, "prod");
    run_op(8'd4, 8'd6, 8'd10,  5, 8'd10, 8'd2, "clamp");
    run_op(8'd0, 8'd9, 8'd7,   3, 8'd0,  8'd0, "zero");
    run_op(8'd2, 8'd6, 8'd11,  5, 8'd11, 8'd2, "both");

    // start pulsed in RUN and on the DONE cycle must not launch another op.
    a_in = 8'd3; b_in = 8'd5; c_in = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 3;
    check("ign_run_state", 32'(dbg_state), 32'd2);
    while (!done && cyc < 64) begin
      tick();
      cyc++;
    end
    check("ign_latency", 32'(cyc), 32'd6);
    check("ign_r5", 32'(r5), 32'd15);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ign_done_busy", 32'(busy), 32'd0);
    ndone = 0;
    repeat (10) begin
      tick();
      if (done || busy) ndone++;
    end
    check("ign_no_extra_op", 32'(ndone), 32'd0);

    // Abort in RUN: back to IDLE, partial iteration count kept, no done.
    a_in = 8'd3; b_in = 8'd5; c_in = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_state", 32'(dbg_state), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_iters", 32'(iters), 32'd1);
    ndone = 0;
    repeat (8) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // Asynchronous reset between edges while in RUN.
    a_in = 8'd3; b_in = 8'd5; c_in = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("rst_pre_sel_r1", 32'(sel_r1), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    reset = 1'b0;
    tick();
    run_op(8'd3, 8'd5, 8'd100, 6, 8'd15, 8'd3, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
